neopixel_frame_sequencer: RTL

- Sequences the NeoPixel strand controller, which takes 50 MHz `clock`.
- Holds a host-writable shadow frame buffer of NUM_PIXELS x {R,G,B} 8-bit levels.
- On a commit request or auto-refresh timeout, snapshots the shadow buffer into an active buffer. It then streams 3*NUM_PIXELS load_color writes into the strand controller, pulses send_it, and tracks the strand's ready_to_send handshake through transmission and the inter-packet wait.

---
 rtl/neopixel_frame_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/neopixel_frame_sequencer.sv
// NeoPixel frame sequencer: the host fills a shadow buffer, and a commit or refresh snapshots it
// into an active buffer that is streamed as color loads, followed by send_it and the strand handshake.
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS     = 5,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int ACK_TIMEOUT    = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_pixel,
  input  logic [1:0]  wr_color,
  input  logic [7:0]  wr_level,
  input  logic        commit,
  input  logic        auto_refresh_en,
  input  logic        ready_to_load,
  input  logic        ready_to_send,
  output logic [7:0]  color_level,
  output logic [1:0]  color_index,
  output logic [2:0]  pixel_index,
  output logic        load_color,
  output logic        send_it,
  output logic        busy,
  output logic        frame_done,
  output logic        send_timeout,
  output logic [15:0] frame_count
);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] ACK_MAX     = TW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]    LAST_PIXEL  = 3'(NUM_PIXELS - 1);
  localparam logic [3:0]    PIXEL_LIMIT = 4'(NUM_PIXELS);

  // IDLE wait start | LOAD stream colors | SEND pulse send_it | WAIT_ACK strand accepts | WAIT_DONE tx + gap
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE} state_t;
  typedef logic [NUM_PIXELS-1:0][2:0][7:0] frame_t;

  state_t        state_q, state_d;
  frame_t        shadow_q, shadow_d, active_q, active_d;
  logic [2:0]    pixel_q, pixel_d;
  logic [1:0]    phase_q, phase_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [TW-1:0] ack_q, ack_d;
  logic          pending_q, pending_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          expired, start;
  logic [1:0]    phase_code;

  // Load order is R, G, B; swapping the phase bits gives the strand codes 00, 10, 01.
  assign phase_code  = {phase_q[0], phase_q[1]};
  assign expired     = (refresh_q == REFRESH_MAX);
  assign start       = (state_q == IDLE) && (pending_q || commit || (auto_refresh_en && expired)) &&
                       ready_to_load && ready_to_send;
  assign frame_count = frame_count_q;

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = start ? 1'b0 : (pending_q | commit);
    refresh_d = refresh_q;
    if (wr_en && ({1'b0, wr_pixel} < PIXEL_LIMIT) && (wr_color != 2'b11))
      shadow_d[wr_pixel][wr_color] = wr_level;
    if (!auto_refresh_en || frame_done || send_timeout)
      refresh_d = '0;
    else if (!expired)
      refresh_d = refresh_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    pixel_d       = pixel_q;
    phase_d       = phase_q;
    ack_d         = ack_q;
    frame_count_d = frame_count_q;
    color_level   = '0;
    color_index   = '0;
    pixel_index   = '0;
    load_color    = 1'b0;
    send_it       = 1'b0;
    frame_done    = 1'b0;
    send_timeout  = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          active_d = shadow_q;
          pixel_d  = '0;
          phase_d  = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_color = ready_to_load;
        if (ready_to_load) begin
          color_index = phase_code;
          pixel_index = pixel_q;
          color_level = active_q[pixel_q][phase_code];
          if (phase_q == 2'd2) begin
            phase_d = '0;
            pixel_d = pixel_q + 3'd1;
            if (pixel_q == LAST_PIXEL)
              state_d = SEND;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      SEND: begin
        send_it = ready_to_send;
        if (ready_to_send) begin
          ack_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!ready_to_send) begin
          state_d = WAIT_DONE;
        end else if (ack_q == ACK_MAX) begin
          send_timeout = 1'b1;
          state_d      = IDLE;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (ready_to_send) begin
          frame_done    = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      active_q      <= '0;
      pixel_q       <= '0;
      phase_q       <= '0;
      refresh_q     <= '0;
      ack_q         <= '0;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pixel_q       <= pixel_d;
      phase_q       <= phase_d;
      refresh_q     <= refresh_d;
      ack_q         <= ack_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule
